// File: rtl/stab_offset_search.sv
// stab_offset_search
// Raster sweep of (x, y) candidate offsets through the XOR correlator core.
// Each candidate is issued with a one-cycle core_go. The controller waits
// (with a per-candidate timeout) for core_done and keeps the minimum
// corr_sum. On ties, the first candidate in raster order is retained.
module stab_offset_search #(
    parameter int OFFSET_W   = 5,
    parameter int X_MAX      = 31,
    parameter int Y_MAX      = 31,
    parameter int SUM_W      = 16,
    parameter int TIMEOUT    = 4095,
    parameter int EARLY_EXIT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                frame_sel,
    output logic                busy,
    output logic                done,
    output logic                timeout_err,
    output logic [OFFSET_W-1:0] best_x,
    output logic [OFFSET_W-1:0] best_y,
    output logic [SUM_W-1:0]    best_sum,
    output logic                core_go,
    output logic [OFFSET_W-1:0] core_x_offset,
    output logic [OFFSET_W-1:0] core_y_offset,
    output logic                core_frame_sel,
    input  logic [SUM_W-1:0]    core_corr_sum,
    input  logic                core_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_NEXT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [OFFSET_W-1:0] X_LAST  = OFFSET_W'(X_MAX);
    localparam logic [OFFSET_W-1:0] Y_LAST  = OFFSET_W'(Y_MAX);
    localparam logic [CNT_W-1:0]    CNT_END = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             first;
    logic             zero_hit;
    logic             last_cand;

    assign last_cand = (core_x_offset == X_LAST) && (core_y_offset == Y_LAST);

    // Status and handshake strobes are decoded from state, so an async reset drops them at once
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_FINISH);
    assign core_go = (state == S_ISSUE);

    // Sweep sequencer, candidate counters, best-candidate tracking and timeout supervision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            first          <= 1'b0;
            zero_hit       <= 1'b0;
            timeout_err    <= 1'b0;
            best_x         <= '0;
            best_y         <= '0;
            best_sum       <= '0;
            core_x_offset  <= '0;
            core_y_offset  <= '0;
            core_frame_sel <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        core_x_offset  <= '0;
                        core_y_offset  <= '0;
                        core_frame_sel <= frame_sel;
                        first          <= 1'b1;
                        timeout_err    <= 1'b0;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    zero_hit <= 1'b0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        if (first || (core_corr_sum < best_sum)) begin
                            best_sum <= core_corr_sum;
                            best_x   <= core_x_offset;
                            best_y   <= core_y_offset;
                        end
                        first    <= 1'b0;
                        zero_hit <= (core_corr_sum == '0);
                        state    <= S_NEXT;
                    end else if (wait_cnt == CNT_END) begin
                        // timed-out candidate leaves first and zero_hit untouched
                        timeout_err <= 1'b1;
                        state       <= S_NEXT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (((EARLY_EXIT != 0) && zero_hit) || last_cand) begin
                        state <= S_FINISH;
                    end else if (core_x_offset == X_LAST) begin
                        core_x_offset <= '0;
                        core_y_offset <= core_y_offset + OFFSET_W'(1);
                        state         <= S_ISSUE;
                    end else begin
                        core_x_offset <= core_x_offset + OFFSET_W'(1);
                        state         <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stab_offset_search.sv
// tb_stab_offset_search
// Randomised scoreboard bench: each sweep's expected result is computed by a
// plain nested-loop minimum search and queued; a monitor pops it on done.
module tb_stab_offset_search;

    localparam int OW  = 5;
    localparam int SW  = 16;
    localparam int XM  = 31;
    localparam int YM  = 31;
    localparam int TMO = 50;
    localparam int EE  = 1;

    logic          clk = 1'b0;
    logic          reset, start, frame_sel, core_done;
    logic [SW-1:0] core_corr_sum;
    logic          busy, done, timeout_err, core_go, core_frame_sel;
    logic [OW-1:0] best_x, best_y, core_x_offset, core_y_offset;
    logic [SW-1:0] best_sum;

    stab_offset_search #(
        .OFFSET_W(OW), .X_MAX(XM), .Y_MAX(YM), .SUM_W(SW),
        .TIMEOUT(TMO), .EARLY_EXIT(EE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_sel(frame_sel),
        .busy(busy), .done(done), .timeout_err(timeout_err),
        .best_x(best_x), .best_y(best_y), .best_sum(best_sum),
        .core_go(core_go), .core_x_offset(core_x_offset),
        .core_y_offset(core_y_offset), .core_frame_sel(core_frame_sel),
        .core_corr_sum(core_corr_sum), .core_done(core_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bx, by, bsum, tmo, ngo, fs;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Core model configuration: 0 abs-distance, 1 abs with zero at (4,2),
    // 2 constant 100, 3 all-ones, 4 random table
    int   mode      = 0;
    int   tbl[1024];
    bit   wh_en     = 1'b0;
    int   lat_fixed = 20;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sum_of(input int x, input int y);
        case (mode)
            0: return iabs(x - 7) + iabs(y - 3) + 5;
            1: return (x == 4 && y == 2) ? 0 : iabs(x - 7) + iabs(y - 3) + 5;
            2: return 100;
            3: return 65535;
            default: return tbl[y * 32 + x];
        endcase
    endfunction

    // Reference: straightforward raster minimum search over the window
    function automatic exp_t ref_sweep(input int fs);
        exp_t e;
        bit   first = 1'b1;
        bit   stop  = 1'b0;
        int   s;
        e.bx = 0; e.by = 0; e.bsum = 0; e.tmo = 0; e.ngo = 0; e.fs = fs;
        for (int y = 0; y <= YM && !stop; y++) begin
            for (int x = 0; x <= XM && !stop; x++) begin
                e.ngo++;
                if (wh_en && x == 2 && y == 0) begin
                    e.tmo = 1;
                    continue;
                end
                s = sum_of(x, y);
                if (first || s < e.bsum) begin
                    e.bsum = s; e.bx = x; e.by = y;
                end
                first = 1'b0;
                if (EE != 0 && s == 0) stop = 1'b1;
            end
        end
        return e;
    endfunction

    // Behavioural correlator core: answers each core_go after a latency,
    // drives garbage on corr_sum outside the done cycle
    initial begin : core_model
        int cnt, cx, cy;
        bit active;
        active = 1'b0; cnt = 0; cx = 0; cy = 0;
        core_done = 1'b0;
        core_corr_sum = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            core_corr_sum = SW'($urandom);
            if (reset) begin
                active = 1'b0;
                continue;
            end
            if (active) begin
                cnt--;
                if (cnt == 0) begin
                    active = 1'b0;
                    chk("offset_stable_x", core_x_offset, cx);
                    chk("offset_stable_y", core_y_offset, cy);
                    core_done = 1'b1;
                    core_corr_sum = SW'(sum_of(cx, cy));
                end
            end
            if (core_go) begin
                cx = core_x_offset;
                cy = core_y_offset;
                cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
                active = !(wh_en && cx == 2 && cy == 0);
            end
        end
    end

    // Monitor: go-pulse spacing and per-sweep scoreboard comparison on done
    initial begin : monitor
        int   gocnt;
        bit   prev_go;
        exp_t e;
        gocnt = 0; prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                gocnt = 0; prev_go = 1'b0;
                continue;
            end
            if (core_go) begin
                chk("go_not_consecutive", prev_go, 0);
                gocnt++;
            end
            prev_go = core_go;
            if (done) begin
                if (sbq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("best_x", best_x, e.bx);
                    chk("best_y", best_y, e.by);
                    chk("best_sum", best_sum, e.bsum);
                    chk("timeout_err", timeout_err, e.tmo);
                    chk("go_count", gocnt, e.ngo);
                    chk("core_frame_sel", core_frame_sel, e.fs);
                    chk("busy_at_done", busy, 1);
                end
                gocnt = 0;
            end
        end
    end

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 40000) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s_done_wait: got no done expected done within 40000 cycles", name);
        end
        @(negedge clk);
        @(negedge clk);
        chk({name, "_busy_after"}, busy, 0);
        chk({name, "_done_after"}, done, 0);
    endtask

    task automatic run_sweep(input string name, input int fs);
        sbq.push_back(ref_sweep(fs));
        @(negedge clk);
        frame_sel = fs[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(name);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) tbl[i] = int'($urandom_range(1, 300));
    endtask

    initial begin : stimulus
        int k;
        reset = 1'b1; start = 1'b0; frame_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_go", core_go, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_fsel", core_frame_sel, 0);
        chk("rst_best", {best_x, best_y, best_sum}, 0);
        chk("rst_offs", {core_x_offset, core_y_offset}, 0);
        reset = 1'b0;
        @(negedge clk);

        mode = 0; lat_fixed = 20;
        run_sweep("abs", 1);

        lat_fixed = 0;
        mode = 1;
        run_sweep("early_exit", 0);
        mode = 4; wh_en = 1'b1; fill_random();
        run_sweep("timeout", 1);
        wh_en = 1'b0;
        mode = 2;
        run_sweep("const100", 0);
        mode = 3;
        run_sweep("ones", 1);

        // Reset mid-WAIT at candidate (10,5)
        mode = 4; fill_random(); lat_fixed = 5;
        @(negedge clk);
        frame_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(core_go && core_x_offset == 10 && core_y_offset == 5) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_10_5", {27'd0, core_x_offset == 10 && core_y_offset == 5}, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_go", core_go, 0);
        chk("midrst_done", done, 0);
        chk("midrst_best", {best_x, best_y, best_sum}, 0);
        chk("midrst_offs", {core_x_offset, core_y_offset}, 0);
        chk("midrst_fsel", core_frame_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        lat_fixed = 0;
        run_sweep("after_reset", 0);

        // start held high with re-pulses and frame_sel toggling
        fill_random();
        sbq.push_back(ref_sweep(1));
        @(negedge clk);
        frame_sel = 1'b1; start = 1'b1;
        k = 0;
        while (k < 40000) begin
            @(negedge clk);
            k++;
            if (done) begin
                start = 1'b0;
                break;
            end
            frame_sel = $urandom_range(0, 1);
            start = (k % 97 == 0) ? 1'b0 : 1'b1;
        end
        frame_sel = 1'b0;
        start = 1'b0;
        wait_done("held_start");
        repeat (5) @(negedge clk);
        chk("held_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
